// File: rtl/foxtrot_pkg.sv
// rtl/foxtrot_pkg.sv - shared word type and address helpers for the memory responder
package foxtrot_pkg;

  typedef logic [63:0] word_t;

  // Word index of a byte address; callers keep the low AW bits.
  function automatic word_t word_index(input word_t addr);
    return addr >> 3;
  endfunction

  // An address is in range when no bit above aw+2 is set.
  function automatic logic addr_in_range(input word_t addr, input int aw);
    return (addr >> (aw + 3)) == 64'd0;
  endfunction

endpackage

// File: rtl/mem_responder_pipe.sv
// rtl/mem_responder_pipe.sv - fixed-latency valid+data response pipe with synchronous clear
module mem_resp_pipe #(
  parameter int LATENCY = 2,
  parameter int W       = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] v;
  logic [W-1:0]       d [LATENCY];

  // Shift valid every cycle; data only advances behind a valid so the last stage holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LATENCY-1];
  assign out_data  = d[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - shared-array memory responder for data and fetch ports
module mem_responder
  import foxtrot_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_ren,
  input  logic [63:0]   mem_raddr,
  output logic          mem_rvalid,
  output logic [63:0]   mem_rdata,
  input  logic          mem_wen,
  input  logic [63:0]   mem_waddr,
  input  logic [63:0]   mem_wdata,
  input  logic          mem_iren,
  input  logic [63:0]   mem_iraddr,
  output logic          mem_irvalid,
  output logic [63:0]   mem_irdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [63:0]   load_data,
  output logic          addr_err
);

  word_t mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx, r_idx, i_idx;
  logic          w_ok, r_ok, i_ok;
  logic          w_act;
  word_t         r_word, i_word;

  assign w_idx = AW'(word_index(mem_waddr));
  assign r_idx = AW'(word_index(mem_raddr));
  assign i_idx = AW'(word_index(mem_iraddr));
  assign w_ok  = addr_in_range(mem_waddr, AW);
  assign r_ok  = addr_in_range(mem_raddr, AW);
  assign i_ok  = addr_in_range(mem_iraddr, AW);

  // Port writes are ignored in reset; load is not.
  assign w_act = mem_wen && w_ok && !rst;

  // Array writes: load always lands, port write is suppressed when it collides with load.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (w_act && !(load_en && load_addr == w_idx)) mem[w_idx] <= mem_wdata;
  end

  // Data-port capture with forwarding of whatever the array will hold after this edge.
  always_comb begin
    r_word = mem[r_idx];
    if (!r_ok)                              r_word = '0;
    else if (load_en && load_addr == r_idx) r_word = load_data;
    else if (w_act && w_idx == r_idx)       r_word = mem_wdata;
  end

  // Fetch-port capture, same forwarding rules as the data port.
  always_comb begin
    i_word = mem[i_idx];
    if (!i_ok)                              i_word = '0;
    else if (load_en && load_addr == i_idx) i_word = load_data;
    else if (w_act && w_idx == i_idx)       i_word = mem_wdata;
  end

  // Sticky range error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else if ((mem_ren && !r_ok) || (mem_iren && !i_ok) || (mem_wen && !w_ok)) addr_err <= 1'b1;
  end

  mem_resp_pipe #(.LATENCY(LATENCY), .W(64)) u_data_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_ren),
    .in_data   (r_word),
    .out_valid (mem_rvalid),
    .out_data  (mem_rdata)
  );

  mem_resp_pipe #(.LATENCY(LATENCY), .W(64)) u_fetch_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_iren),
    .in_data   (i_word),
    .out_valid (mem_irvalid),
    .out_data  (mem_irdata)
  );

endmodule

// File: doc/mem_responder.md
# mem_responder

Behavioural memory responder that serves the CPU's two memory ports: data read/write (`mem_*`) and instruction fetch (`mem_i*`). It sits outside `cpu` in the testbench top as the responding end of both read-request/valid handshakes. It is backed by one shared word array. Each read port returns data a fixed `LATENCY` cycles after the request and can accept a new request every cycle.

## Interface
- `DEPTH_WORDS`, default 4096: number of 64-bit words in the backing array.
- `LATENCY`, default 2: cycles from request edge to `*rvalid`; legal range 1..8.
- `AW`, default `$clog2(DEPTH_WORDS)`: word-index width (derived, not overridden).

Ports:
- `clk` input 1: clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_ren` input 1: data read request, sampled each cycle.
- `mem_raddr` input 64: data read byte address.
- `mem_rvalid` output 1: data read response valid (one-cycle pulse per request).
- `mem_rdata` output 64: data read response word.
- `mem_wen` input 1: data write, sampled each cycle.
- `mem_waddr` input 64: write byte address.
- `mem_wdata` input 64: write word.
- `mem_iren` input 1: fetch request.
- `mem_iraddr` input 64: fetch byte address.
- `mem_irvalid` output 1: fetch response valid.
- `mem_irdata` output 64: fetch response word.
- `load_en` input 1: bench preload write, takes priority over `mem_wen`.
- `load_addr` input `AW`: preload word index.
- `load_data` input 64: preload word.
- `addr_err` output 1: sticky out-of-range flag.

## Operation
- Word index is `addr[AW+2:3]`. Bits [2:0] are ignored (8-byte aligned). An address is out of range if any bit above `AW+2` is set.
- Read request: a cycle with `ren`=1 captures the word at that edge. Out-of-range reads capture 64'h0 and set `addr_err`.
- Write/read same cycle, same index: the read captures the new `mem_wdata` (write-through forwarding). This applies to both read ports.
- Write: when `mem_wen`=1 and the address is in range, `array[idx] <= mem_wdata` at the edge. Out-of-range writes are dropped and set `addr_err`.
- `load_en` and `mem_wen` in the same cycle: both writes happen if the indices differ. If the indices are equal, `load_data` wins.
- Captured word plus a valid bit enter a `LATENCY`-deep shift pipe per port. `*rvalid`/`*rdata` are driven from the pipe's last stage.
- Responses are strictly in request order. Back-to-back requests give back-to-back responses. There is no backpressure and no stall.
- `*rdata` holds its last value when `*rvalid`=0. Consumers must qualify with `*rvalid`.
- The array is not cleared by reset. Contents persist across `rst`, so preload survives reset.

## Timing
- Reset values: `mem_rvalid`=0, `mem_irvalid`=0, `mem_rdata`=0, `mem_irdata`=0, `addr_err`=0. All pipe valid bits are cleared.
- Reset mid-operation: all in-flight responses are discarded, with no `rvalid` after the reset edge. Requests presented while `rst`=1 are ignored, and writes while `rst`=1 are ignored. `load_en` is still honoured during reset.
- Request at edge N gives `rvalid`=1 in the cycle following edge N+LATENCY−1. That is, it is visible `LATENCY` cycles after the request cycle.
- Throughput: 1 request per cycle per port. Maximum in flight per port is `LATENCY`.
- A write at edge N is visible to reads issued at edge N (forwarded) and later.
- `addr_err` sets at the edge of the offending access and clears only on `rst`.

## Structure
- Shared package `foxtrot_pkg`: `word_t` (logic [63:0]), function `word_index(addr)`, function `addr_in_range(addr)`. Use these instead of local slicing.
- Sub-module `mem_resp_pipe` (parameters `LATENCY`, width 64): valid+data shift pipe with synchronous clear, instantiated twice (data and fetch).
- Top holds the array, write arbitration, forwarding muxes and the error flag.

## Test plan
- **Latency:** preload word 5 = 64'hDEAD_BEEF_0000_0005; `mem_ren` with `mem_raddr`=64'h28 at cycle 10 → `mem_rvalid`=1 with that data at cycle 12 only (`LATENCY`=2).
- **Streaming:** fetch `mem_iraddr` 0x0, 0x8, 0x10 on consecutive cycles with words 0..2 preloaded as 1, 2, 3 → `mem_irvalid` high 3 consecutive cycles, `mem_irdata` 1, 2, 3.
- **Forwarding:** same cycle `mem_wen` to 0x40 with 64'h77, `mem_ren` and `mem_iren` at 0x40 → both responses return 64'h77. A later read also returns 64'h77.
- **Collision priority:** `load_en` idx 8 = 64'hA and `mem_wen` 0x40 = 64'hB same cycle → subsequent read of 0x40 returns 64'hA.
- **Reset mid-flight:** request at cycle 20, `rst` at cycle 21 → no `rvalid` at cycle 22. Array contents are unchanged after reset.
- **Range error:** read at 64'h1_0000_0000 (`DEPTH_WORDS`=4096) → response 64'h0, `addr_err`=1 and held until `rst`.
